// File: rtl/video_sched_pkg.sv
// Shared constants and FSM encoding for the video line scheduler.
package video_sched_pkg;

    localparam int ACTIVE_LINES = 240;
    localparam int LB_ADDR_W    = 10;
    localparam int LINE_W       = 9;
    localparam int HSCALE_FRAC  = 7;
    localparam int HSCALE_W     = 8;
    localparam int LCNT_W       = 8;
    localparam int ACC_W        = LB_ADDR_W + HSCALE_FRAC + 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RENDER = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;

    // Interlaced fields interleave: source line = 2k + field.
    function automatic logic [LINE_W-1:0] src_line(input logic [LCNT_W-1:0] k,
                                                   input logic intl, input logic fld);
        return intl ? {k, fld} : {1'b0, k};
    endfunction

endpackage

// File: rtl/video_hscale_acc.sv
// Horizontal fixed-point pixel accumulator producing a saturating line-buffer address.
module video_hscale_acc
    import video_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 step_i,
    input  logic [HSCALE_W-1:0]  scale_i,
    output logic [LB_ADDR_W-1:0] addr_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {{(ACC_W + 1 - HSCALE_W){1'b0}}, scale_i};
        acc_d = acc_q;
        if (clear_i)
            acc_d = '0;
        else if (step_i)
            // Pin at all-ones so a long line can never wrap back to low addresses.
            acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign addr_o = acc_q[ACC_W-1] ? '1 : acc_q[ACC_W-2:HSCALE_FRAC];

endmodule

// File: rtl/video_line_scheduler.sv
// Schedules per-line render requests into a ping-pong line buffer and
// generates the display read address.
module video_line_scheduler
    import video_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 next_frame,
    input  logic                 next_line,
    input  logic                 next_pixel,
    input  logic                 current_field,
    input  logic                 interlaced,
    input  logic [HSCALE_W-1:0]  hscale,
    output logic                 render_start,
    output logic [LINE_W-1:0]    render_line,
    output logic                 render_buf,
    input  logic                 render_done,
    output logic                 disp_buf,
    output logic [LB_ADDR_W-1:0] disp_addr,
    output logic                 underrun,
    input  logic                 underrun_clr
);

    localparam logic [LCNT_W-1:0] LAST_K = LCNT_W'(ACTIVE_LINES - 1);

    state_t              state_q, state_d;
    logic [LCNT_W-1:0]   k_q, k_d, k_next;
    logic                intl_q, intl_d, fld_q, fld_d;
    logic [HSCALE_W-1:0] hscale_q, hscale_d;
    logic                start_q, start_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                buf_q, buf_d;
    logic                underrun_q, underrun_d;
    logic                ur_set;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        intl_d   = intl_q;
        fld_d    = fld_q;
        hscale_d = next_line ? hscale : hscale_q;
        start_d  = 1'b0;
        line_d   = line_q;
        buf_d    = buf_q;
        ur_set   = 1'b0;
        k_next   = k_q + 1'b1;

        if (next_frame) begin
            intl_d  = interlaced;
            fld_d   = current_field;
            k_d     = '0;
            start_d = 1'b1;
            line_d  = src_line('0, interlaced, current_field);
            state_d = ST_RENDER;
        end else if (next_line) begin
            buf_d = ~buf_q;
            if (state_q != ST_IDLE) begin
                k_d    = k_next;
                // A done arriving with the swap still counts as on time.
                ur_set = (state_q == ST_RENDER) && !render_done;
                if (k_q < LAST_K) begin
                    start_d = 1'b1;
                    line_d  = src_line(k_next, intl_q, fld_q);
                    state_d = ST_RENDER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end else if (state_q == ST_RENDER && render_done) begin
            state_d = ST_WAIT;
        end

        underrun_d = ur_set | (underrun_q & ~underrun_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            intl_q     <= 1'b0;
            fld_q      <= 1'b0;
            hscale_q   <= '0;
            start_q    <= 1'b0;
            line_q     <= '0;
            buf_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            intl_q     <= intl_d;
            fld_q      <= fld_d;
            hscale_q   <= hscale_d;
            start_q    <= start_d;
            line_q     <= line_d;
            buf_q      <= buf_d;
            underrun_q <= underrun_d;
        end
    end

    video_hscale_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (next_line),
        .step_i  (next_pixel),
        .scale_i (hscale_q),
        .addr_o  (disp_addr)
    );

    assign render_start = start_q;
    assign render_line  = line_q;
    assign render_buf   = buf_q;
    assign disp_buf     = ~buf_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_video_line_scheduler.sv
// Directed-plus-random bench for video_line_scheduler against an arithmetic reference.
module tb_video_line_scheduler;

    logic       clk = 1'b0;
    logic       rst, next_frame, next_line, next_pixel, current_field, interlaced;
    logic       render_done, underrun_clr;
    logic [7:0] hscale;
    logic       render_start, render_buf, disp_buf, underrun;
    logic [8:0] render_line;
    logic [9:0] disp_addr;

    int   n_tests = 0, n_fail = 0, n_starts = 0, base = 0;
    logic exp_buf = 1'b0, exp_ur = 1'b0;

    always #5 clk = ~clk;

    video_line_scheduler dut (
        .clk(clk), .rst(rst), .next_frame(next_frame), .next_line(next_line),
        .next_pixel(next_pixel), .current_field(current_field), .interlaced(interlaced),
        .hscale(hscale), .render_start(render_start), .render_line(render_line),
        .render_buf(render_buf), .render_done(render_done), .disp_buf(disp_buf),
        .disp_addr(disp_addr), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    always @(posedge clk) if (render_start === 1'b1) n_starts <= n_starts + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input int line);
        chk("render_start", render_start, 1);
        chk("render_line", render_line, line);
        chk("render_buf", render_buf, exp_buf);
        chk("disp_buf", disp_buf, !exp_buf);
    endtask

    // wl: withhold done; sl: done with next_line; cl: clear with new underrun.
    task automatic do_frame(input bit intl, input bit fld, input int stop, input int wl,
                            input int sl, input int cl, input int dmin, input int dmax);
        int line;
        interlaced = intl; current_field = fld; next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        interlaced = ~intl; current_field = ~fld;
        for (int i = 0; i < 240; i++) begin
            line = intl ? 2 * i + int'(fld) : i;
            chk_req(line);
            if (i == stop) return;
            tick();
            chk("start_pulse", render_start, 0);
            if (exp_ur && (i == wl + 1 || i == cl + 1)) begin
                underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
                exp_ur = 1'b0;
                chk("underrun_clr", underrun, 0);
            end
            repeat ($urandom_range(dmax, dmin)) tick();
            if (i != wl && i != sl && i != cl) begin
                render_done = 1'b1; tick(); render_done = 1'b0;
                if ($urandom_range(3, 0) == 0) begin
                    tick(); render_done = 1'b1; tick(); render_done = 1'b0;
                end
            end
            next_line = 1'b1; render_done = (i == sl); underrun_clr = (i == cl);
            tick();
            next_line = 1'b0; render_done = 1'b0; underrun_clr = 1'b0;
            exp_buf = ~exp_buf;
            if (i == wl || i == cl) exp_ur = 1'b1;
            chk("underrun", underrun, exp_ur);
        end
        chk("end_no_start", render_start, 0);
    endtask

    task automatic pix_line(input logic [7:0] h, input int n, input bit gaps);
        int e, np;
        np = 0;
        hscale = h; next_line = 1'b1;
        tick();
        next_line = 1'b0; exp_buf = ~exp_buf;
        hscale = 8'($urandom);
        chk("pix_clear", disp_addr, 0);
        chk("idle_no_start", render_start, 0);
        for (int j = 0; j < n; j++) begin
            next_pixel = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            if (next_pixel) np++;
            tick();
            e = (np * int'(h)) / 128;
            if (e > 1023) e = 1023;
            chk("disp_addr", disp_addr, e);
        end
        next_pixel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; next_frame = 0; next_line = 0; next_pixel = 0; current_field = 0;
        interlaced = 0; render_done = 0; underrun_clr = 0; hscale = 0;
        repeat (2) tick();
        chk("rst_start", render_start, 0);
        chk("rst_line", render_line, 0);
        chk("rst_buf", render_buf, 0);
        chk("rst_disp_buf", disp_buf, 1);
        chk("rst_addr", disp_addr, 0);
        chk("rst_underrun", underrun, 0);
        rst = 1'b0;
        tick();

        // Idle next_line only swaps buffers.
        base = n_starts;
        next_line = 1'b1; render_done = 1'b1; tick(); next_line = 0; render_done = 0;
        exp_buf = ~exp_buf;
        chk("idle_buf", render_buf, exp_buf);
        tick();
        chk("idle_starts", n_starts - base, 0);

        pix_line(8'd64, 1280, 1'b0);
        pix_line(8'd255, 1280, 1'b0);
        pix_line(8'($urandom_range(255, 1)), 700, 1'b1);

        base = n_starts;
        do_frame(1'b0, 1'b0, 240, -1, -1, -1, 99, 99);
        tick();
        chk("frame1_starts", n_starts - base, 240);
        chk("frame1_underrun", underrun, 0);
        next_line = 1'b1; tick(); next_line = 0; exp_buf = ~exp_buf;
        tick();
        chk("frame1_idle", n_starts - base, 240);

        base = n_starts;
        do_frame(1'b1, 1'b1, 240, -1, -1, -1, 1, 20);
        tick();
        chk("frame2_starts", n_starts - base, 240);

        do_frame(1'b0, 1'b0, 14, 5, 7, 10, 1, 8);

        // Restart mid-sequence, then reset while rendering line 100.
        hscale = 8'd200;
        do_frame(1'b0, 1'b1, 100, 99, -1, -1, 1, 4);
        chk("pre_rst_underrun", underrun, 1);
        next_pixel = 1'b1; repeat (10) tick(); next_pixel = 1'b0;
        chk("pre_rst_addr", disp_addr, 15);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_start", render_start, 0);
        chk("mid_rst_line", render_line, 0);
        chk("mid_rst_buf", render_buf, 0);
        chk("mid_rst_disp_buf", disp_buf, 1);
        chk("mid_rst_addr", disp_addr, 0);
        chk("mid_rst_underrun", underrun, 0);
        tick();
        rst = 1'b0; exp_buf = 1'b0; exp_ur = 1'b0;
        base = n_starts;
        repeat (5) tick();
        render_done = 1'b1; tick(); render_done = 1'b0;
        next_line = 1'b1; tick(); next_line = 1'b0; exp_buf = ~exp_buf;
        tick();
        chk("post_rst_starts", n_starts - base, 0);
        chk("post_rst_buf", render_buf, exp_buf);

        do_frame(1'b1, 1'b0, 3, -1, -1, -1, 1, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_line_scheduler.md
VIDEO_LINE_SCHEDULER -- requirements
Module: video_line_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: system/pixel clock, same domain as composite timing generator.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port next_frame, input, 1 bit: one-cycle pulse one line before first active line of a field.
REQ-004 SHALL have port next_line, input, 1 bit: one-cycle pulse one cycle before each line's active region.
REQ-005 SHALL have port next_pixel, input, 1 bit: high during active pixel cycles.
REQ-006 SHALL have port current_field, input, 1 bit: field of upcoming frame, valid with next_frame (0 even, 1 odd).
REQ-007 SHALL have port interlaced, input, 1 bit: config, 1 = interlaced line numbering.
REQ-008 SHALL have port hscale, input, 8 bits: pixel advance per active cycle, unsigned 1.7 fixed point (128 = 1.0).
REQ-009 SHALL have port render_start, output, 1 bit: one-cycle pulse requesting render of render_line into render_buf.
REQ-010 SHALL have port render_line, output, 9 bits: source line number to render.
REQ-011 SHALL have port render_buf, output, 1 bit: line-buffer half the renderer writes.
REQ-012 SHALL have port render_done, input, 1 bit: one-cycle pulse from renderer, current request complete.
REQ-013 SHALL have port disp_buf, output, 1 bit: line-buffer half being displayed; always equals !render_buf.
REQ-014 SHALL have port disp_addr, output, 10 bits: line-buffer read address for palette lookup.
REQ-015 SHALL have port underrun, output, 1 bit: sticky flag, a line swap occurred before render_done.
REQ-016 SHALL have port underrun_clr, input, 1 bit: pulse clearing underrun.

Function
REQ-017 SHALL implement FSM states IDLE, RENDER, WAIT; transitions only on clk edges.
REQ-018 On next_frame: latch interlaced and current_field; clear line count k to 0; issue render_start next cycle with render_line = interlaced ? field : 0; enter RENDER. Takes priority over next_line in the same cycle and restarts a sequence in progress.
REQ-019 In RENDER, render_done moves FSM to WAIT, and the request counts complete.
REQ-020 On next_line in RENDER or WAIT: toggle render_buf/disp_buf; k increments; if k+1 < 240, issue render_start next cycle with render_line = interlaced ? 2(k+1)+field : k+1 and enter RENDER; otherwise enter IDLE.
REQ-021 next_line while in RENDER without render_done in the same cycle SHALL set underrun; swap and next request proceed regardless.
REQ-022 render_done and next_line in the same cycle SHALL count as completed: no underrun.
REQ-023 render_done in IDLE or WAIT SHALL be ignored.
REQ-024 next_line in IDLE SHALL only toggle buffers; no render_start.
REQ-025 render_start latency SHALL be exactly 1 cycle after the triggering next_frame/next_line; render_line/render_buf stable from render_start until next request.
REQ-026 Horizontal accumulator acc (18 bits) SHALL clear to 0 on next_line and add latched hscale on each next_pixel cycle; hscale latched on next_line.
REQ-027 disp_addr SHALL equal acc[16:7], saturating at 1023 when acc[17] or acc[16:7] would exceed 1023.
REQ-028 underrun_clr and a new underrun in the same cycle: underrun SHALL remain set.

Reset
REQ-029 On rst: FSM IDLE, k=0, render_start=0, render_line=0, render_buf=0 (disp_buf=1), acc=0 (disp_addr=0), underrun=0, latched interlaced/field/hscale=0.
REQ-030 Reset mid-RENDER SHALL drop the request silently; no render_start until the next next_frame.

Structure
REQ-031 Shared package video_sched_pkg SHALL hold ACTIVE_LINES=240, LB_ADDR_W=10, LINE_W=9, HSCALE_FRAC=7, and the FSM state type.
REQ-032 Accumulator/saturation SHALL be a sub-module video_hscale_acc (clear, step, scale in; addr out).

Verification
REQ-033 next_frame, field=0, interlaced=0; render_done 100 cycles after each start -> render_line 0,1,...,239, 240 render_starts, then IDLE, underrun=0.
REQ-034 interlaced=1, field=1 -> render_line sequence 1,3,5,...,479.
REQ-035 Withhold render_done for line 5 -> underrun=1 at that next_line, render_start for line 6 still issued; underrun_clr clears it.
REQ-036 render_done same cycle as next_line -> underrun stays 0.
REQ-037 hscale=64, 1280 next_pixel cycles -> disp_addr 0,0,1,1,...,639; hscale=255 -> disp_addr saturates at 1023.
REQ-038 rst asserted mid-RENDER at line 100 -> all outputs at reset values immediately; next next_frame restarts at line 0.
